// File: rtl/pc_next_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_gen_if
// Brief    : Signal bundle between the next-PC sequencer and the pipeline.
// Revision : 1.0
// ============================================================================
interface pc_next_gen_if;
    logic [31:0] pc_cur;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        flush_if;
    logic        flush_id;
    logic [31:0] epc;
    logic        misalign;

    modport master (
        output pc_cur, stall, br_taken, br_target, trap,
        input  pc_next, pc_en, flush_if, flush_id, epc, misalign
    );

    modport slave (
        input  pc_cur, stall, br_taken, br_target, trap,
        output pc_next, pc_en, flush_if, flush_id, epc, misalign
    );
endinterface
`default_nettype wire

// File: rtl/pc_next_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_gen
// Brief    : Next-PC sequencer: picks PC+4, redirect, held redirect, trap or
//            reset vector, and raises the matching pipeline flushes.
// Revision : 1.0
// ============================================================================
module pc_next_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input  logic          clk,
    input  logic          rst,
    pc_next_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pend_addr;
    logic        r_pend_v;
    logic [31:0] r_epc;
    logic        r_misalign;

    logic [31:0] w_pc_next;
    logic        w_pc_en;
    logic        w_flush;
    logic        w_br_bad;
    logic        w_trap_evt;
    logic        w_mis_evt;
    logic        w_pend_load;
    logic        w_pend_clr;

    assign w_br_bad = bus.br_taken && (bus.br_target[1:0] != 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_next   = bus.pc_cur + 32'd4;
        w_pc_en     = ~bus.stall;
        w_flush     = 1'b0;
        w_trap_evt  = 1'b0;
        w_mis_evt   = 1'b0;
        w_pend_load = 1'b0;
        w_pend_clr  = 1'b0;
        if (!rst) begin
            w_pc_next   = RESET_VECTOR;
            w_pc_en     = 1'b1;
            w_flush     = 1'b1;
            w_state_nxt = ST_BOOT;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    w_pc_next   = RESET_VECTOR;
                    w_pc_en     = 1'b1;
                    w_flush     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
                ST_RUN, ST_HOLD: begin
                    // Misaligned redirects are trapped before they can be held.
                    if (bus.trap || w_br_bad) begin
                        w_pc_next   = TRAP_VECTOR;
                        w_pc_en     = 1'b1;
                        w_flush     = 1'b1;
                        w_trap_evt  = 1'b1;
                        w_mis_evt   = ~bus.trap;
                        w_pend_clr  = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else if (bus.br_taken && !bus.stall) begin
                        w_pc_next   = bus.br_target;
                        w_pc_en     = 1'b1;
                        w_flush     = 1'b1;
                        w_pend_clr  = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else if (bus.br_taken) begin
                        w_pc_en     = 1'b0;
                        w_pend_load = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else if (r_state == ST_HOLD && r_pend_v) begin
                        if (bus.stall) begin
                            w_pc_en = 1'b0;
                        end else begin
                            w_pc_next   = r_pend_addr;
                            w_pc_en     = 1'b1;
                            w_flush     = 1'b1;
                            w_pend_clr  = 1'b1;
                            w_state_nxt = ST_RUN;
                        end
                    end
                end
                default: begin
                    w_pc_next   = RESET_VECTOR;
                    w_pc_en     = 1'b1;
                    w_flush     = 1'b1;
                    w_state_nxt = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_BOOT;
            r_pend_addr <= 32'd0;
            r_pend_v    <= 1'b0;
            r_epc       <= 32'd0;
            r_misalign  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_misalign <= w_mis_evt;
            if (w_trap_evt) begin
                r_epc <= bus.pc_cur;
            end
            if (w_pend_load) begin
                r_pend_addr <= bus.br_target;
                r_pend_v    <= 1'b1;
            end else if (w_pend_clr) begin
                r_pend_v    <= 1'b0;
            end
        end
    end

    assign bus.pc_next  = w_pc_next;
    assign bus.pc_en    = w_pc_en;
    assign bus.flush_if = w_flush;
    assign bus.flush_id = w_flush;
    assign bus.epc      = r_epc;
    assign bus.misalign = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_next_gen
// Brief    : Directed and randomized checks of pc_next_gen against a
//            cycle-level reference model of the sequencing rules.
// Revision : 1.0
// ============================================================================
module tb_pc_next_gen;

    localparam logic [31:0] C_RV = 32'h0000_0000;
    localparam logic [31:0] C_TV = 32'h0000_0010;

    logic clk;
    logic rst;
    pc_next_gen_if bus ();

    pc_next_gen #(.RESET_VECTOR(C_RV), .TRAP_VECTOR(C_TV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: abstract state is "booting", "a redirect is waiting",
    // the waiting address, and the two trap-report registers.
    bit          m_boot;
    bit          m_pend;
    logic [31:0] m_paddr;
    logic [31:0] m_epc;
    logic        m_mis;
    bit          m_pend_n;
    logic [31:0] m_paddr_n;
    bit          m_trap_evt;
    bit          m_mis_evt;
    logic [31:0] exp_pc;
    logic        exp_en;
    logic        exp_fl;

    task automatic model_eval();
        bit bad;
        bad        = bus.br_taken && (bus.br_target[1:0] != 2'b00);
        m_trap_evt = 0;
        m_mis_evt  = 0;
        m_pend_n   = m_pend;
        m_paddr_n  = m_paddr;
        exp_pc     = bus.pc_cur + 32'd4;
        exp_en     = ~bus.stall;
        exp_fl     = 1'b0;
        if (!rst || m_boot) begin
            exp_pc = C_RV; exp_en = 1'b1; exp_fl = 1'b1;
        end else if (bus.trap || bad) begin
            exp_pc = C_TV; exp_en = 1'b1; exp_fl = 1'b1;
            m_trap_evt = 1; m_mis_evt = !bus.trap; m_pend_n = 0;
        end else if (bus.br_taken) begin
            if (bus.stall) begin
                exp_en = 1'b0; m_pend_n = 1; m_paddr_n = bus.br_target;
            end else begin
                exp_pc = bus.br_target; exp_en = 1'b1; exp_fl = 1'b1; m_pend_n = 0;
            end
        end else if (m_pend) begin
            if (bus.stall) exp_en = 1'b0;
            else begin
                exp_pc = m_paddr; exp_en = 1'b1; exp_fl = 1'b1; m_pend_n = 0;
            end
        end
    endtask

    // Drive inputs just after a rising edge; return at the falling edge.
    task automatic set_in(input logic s, input logic b, input logic [31:0] t, input logic tr);
        bus.stall = s; bus.br_taken = b; bus.br_target = t; bus.trap = tr;
        #4;
        model_eval();
    endtask

    // Advance one clock: the model commits and the PC register loads.
    task automatic tick();
        logic [31:0] pc_old;
        pc_old = bus.pc_cur;
        @(posedge clk);
        if (!rst) begin
            m_boot = 1; m_pend = 0; m_paddr = '0; m_epc = '0; m_mis = 1'b0;
        end else if (m_boot) begin
            m_boot = 0; m_mis = 1'b0;
        end else begin
            m_mis = m_mis_evt;
            if (m_trap_evt) m_epc = pc_old;
            m_pend = m_pend_n; m_paddr = m_paddr_n;
        end
        #1;
        if (exp_en) bus.pc_cur = exp_pc;
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.pc_cur = 32'h0;
        set_in(0, 0, 32'h0, 0); tick();
        set_in(0, 0, 32'h0, 0); tick();
        set_in(1, 1, 32'h44, 1);
        checks++;
        if ({bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id} !== {C_RV, 3'b111}) begin
            errors++; $display("FAIL reset_outputs: got pc=%h en=%b fi=%b fd=%b want pc=%h en/flush=1",
                bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id, C_RV);
        end
        checks++;
        if ({bus.epc, bus.misalign} !== {32'h0, 1'b0}) begin
            errors++; $display("FAIL reset_regs: got epc=%h mis=%b want 0/0", bus.epc, bus.misalign);
        end
        tick();
        rst = 1'b1; bus.pc_cur = 32'h0;
        set_in(0, 0, 32'h0, 0);
        checks++;
        if ({bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id} !== {C_RV, 3'b111}) begin
            errors++; $display("FAIL boot_cycle: got pc=%h en=%b fi=%b fd=%b want pc=%h 111",
                bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id, C_RV);
        end
        tick();
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            set_in(0, 0, 32'h0, 0);
            checks++;
            if ({bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id} !== {32'(4 * i), 3'b100}) begin
                errors++; $display("FAIL seq_%0d: got pc=%h en=%b fi=%b fd=%b want pc=%h en=1 flush=0",
                    i, bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id, 32'(4 * i));
            end
            tick();
        end
    endtask

    task automatic test_branch();
        bus.pc_cur = 32'h100;
        set_in(0, 1, 32'h200, 0);
        checks++;
        if ({bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id} !== {32'h200, 3'b111}) begin
            errors++; $display("FAIL branch_unstalled: got pc=%h en=%b fi=%b fd=%b want 200/111",
                bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id);
        end
        tick();
    endtask

    task automatic test_stall_redirect();
        for (int i = 0; i < 3; i++) begin
            set_in(1, (i == 0), 32'h300, 0);
            checks++;
            if ({bus.pc_en, bus.flush_if, bus.flush_id} !== 3'b000) begin
                errors++; $display("FAIL stall_hold_%0d: got en=%b fi=%b fd=%b want 000",
                    i, bus.pc_en, bus.flush_if, bus.flush_id);
            end
            tick();
        end
        set_in(0, 0, 32'h0, 0);
        checks++;
        if ({bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id} !== {32'h300, 3'b111}) begin
            errors++; $display("FAIL stall_release: got pc=%h en=%b fi=%b fd=%b want 300/111",
                bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id);
        end
        tick();
    endtask

    task automatic test_misalign();
        bus.pc_cur = 32'h40;
        set_in(0, 1, 32'h202, 0);
        checks++;
        if ({bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id} !== {C_TV, 3'b111}) begin
            errors++; $display("FAIL misalign_vec: got pc=%h en=%b fi=%b fd=%b want %h/111",
                bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id, C_TV);
        end
        tick();
        checks++;
        if ({bus.epc, bus.misalign} !== {32'h40, 1'b1}) begin
            errors++; $display("FAIL misalign_regs: got epc=%h mis=%b want 40/1", bus.epc, bus.misalign);
        end
        set_in(0, 0, 32'h0, 0);
        tick();
        checks++;
        if (bus.misalign !== 1'b0) begin
            errors++; $display("FAIL misalign_pulse: got mis=%b want 0", bus.misalign);
        end
    endtask

    task automatic test_trap_priority();
        bus.pc_cur = 32'h80;
        set_in(1, 1, 32'h500, 1);
        checks++;
        if ({bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id} !== {C_TV, 3'b111}) begin
            errors++; $display("FAIL trap_prio: got pc=%h en=%b fi=%b fd=%b want %h/111",
                bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id, C_TV);
        end
        tick();
        checks++;
        if ({bus.epc, bus.misalign} !== {32'h80, 1'b0}) begin
            errors++; $display("FAIL trap_epc: got epc=%h mis=%b want 80/0", bus.epc, bus.misalign);
        end
        set_in(0, 0, 32'h0, 0);
        checks++;
        if ({bus.pc_next, bus.pc_en, bus.flush_if} !== {C_TV + 32'd4, 2'b10}) begin
            errors++; $display("FAIL trap_discard: got pc=%h en=%b fi=%b want %h/1/0",
                bus.pc_next, bus.pc_en, bus.flush_if, C_TV + 32'd4);
        end
        tick();
    endtask

    task automatic test_reset_in_hold();
        set_in(1, 1, 32'h600, 0); tick();
        rst = 1'b0;
        set_in(1, 0, 32'h0, 0);
        checks++;
        if ({bus.pc_next, bus.pc_en, bus.flush_if} !== {C_RV, 2'b11}) begin
            errors++; $display("FAIL hold_reset: got pc=%h en=%b fi=%b want %h/11",
                bus.pc_next, bus.pc_en, bus.flush_if, C_RV);
        end
        tick();
        rst = 1'b1;
        set_in(0, 0, 32'h0, 0);
        checks++;
        if ({bus.pc_next, bus.pc_en, bus.flush_if} !== {C_RV, 2'b11}) begin
            errors++; $display("FAIL hold_boot: got pc=%h en=%b fi=%b want %h/11",
                bus.pc_next, bus.pc_en, bus.flush_if, C_RV);
        end
        tick();
        set_in(0, 0, 32'h0, 0);
        checks++;
        if ({bus.pc_next, bus.flush_if} !== {C_RV + 32'd4, 1'b0}) begin
            errors++; $display("FAIL hold_dropped: got pc=%h fi=%b want %h/0 (not 600)",
                bus.pc_next, bus.flush_if, C_RV + 32'd4);
        end
        tick();
    endtask

    task automatic test_wrap();
        bus.pc_cur = 32'hFFFF_FFFC;
        set_in(0, 0, 32'h0, 0);
        checks++;
        if ({bus.pc_next, bus.pc_en, bus.flush_if} !== {32'h0, 2'b10}) begin
            errors++; $display("FAIL wrap: got pc=%h en=%b fi=%b want 0/1/0",
                bus.pc_next, bus.pc_en, bus.flush_if);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 7) == 0) bus.pc_cur = {$urandom} & 32'hFFFF_FFFC;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            set_in(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), tgt,
                   ($urandom_range(0, 15) == 0));
            checks++;
            if (bus.pc_en !== exp_en || bus.flush_if !== exp_fl || bus.flush_id !== exp_fl ||
                (exp_en && bus.pc_next !== exp_pc)) begin
                errors++; $display("FAIL rand_comb[%0d]: got pc=%h en=%b fi=%b fd=%b want pc=%h en=%b fl=%b",
                    n, bus.pc_next, bus.pc_en, bus.flush_if, bus.flush_id, exp_pc, exp_en, exp_fl);
            end
            tick();
            checks++;
            if ({bus.epc, bus.misalign} !== {m_epc, m_mis}) begin
                errors++; $display("FAIL rand_regs[%0d]: got epc=%h mis=%b want epc=%h mis=%b",
                    n, bus.epc, bus.misalign, m_epc, m_mis);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.pc_cur = '0; bus.stall = 1'b0; bus.br_taken = 1'b0;
        bus.br_target = '0; bus.trap = 1'b0;
        m_boot = 1; m_pend = 0; m_paddr = '0; m_epc = '0; m_mis = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_sequential();
        test_branch();
        test_stall_redirect();
        test_misalign();
        test_trap_priority();
        test_reset_in_hold();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
